// File: rtl/mips_ctrl_fsm_if.sv
// Instruction/handshake bundle between the miniMIPS sequencer, register file, ALU and the control FSM.
// The sequencer/datapath side uses master; the control unit uses slave.
interface mips_ctrl_fsm_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  START;
    logic [5:0]            OpCode;
    logic [5:0]            Funct;
    logic [4:0]            Shamt;
    logic [15:0]           Imm16;
    logic [DATA_WIDTH-1:0] DATA_R1;
    logic [DATA_WIDTH-1:0] DATA_R2;
    logic                  READ;
    logic                  WRITE;
    logic [DATA_WIDTH-1:0] ALU_OP1;
    logic [DATA_WIDTH-1:0] ALU_OP2;
    logic [5:0]            ALU_Code;
    logic                  BUSY;
    logic                  DONE;
    logic                  ERR;

    modport master (
        output START, OpCode, Funct, Shamt, Imm16, DATA_R1, DATA_R2,
        input  READ, WRITE, ALU_OP1, ALU_OP2, ALU_Code, BUSY, DONE, ERR
    );

    modport slave (
        input  START, OpCode, Funct, Shamt, Imm16, DATA_R1, DATA_R2,
        output READ, WRITE, ALU_OP1, ALU_OP2, ALU_Code, BUSY, DONE, ERR
    );
endinterface

// File: rtl/mips_ctrl_fsm.sv
// Multi-cycle miniMIPS control unit: register read, ALU execute and write-back sequenced by
// cycle counters. Outputs are registered from the internal state, so they trail it by one cycle.
module mips_ctrl_fsm #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          RF_READ_LAT = 1,
    parameter int          ALU_LAT     = 1,
    parameter logic [5:0]  NOP_OPCODE  = 6'd63
) (
    input  logic              CLK,
    input  logic              RST,
    mips_ctrl_fsm_if.slave    bus
);

    localparam int MAX_LAT = (RF_READ_LAT > ALU_LAT) ? RF_READ_LAT : ALU_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT);

    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RF_READ_LAT - 1);
    localparam logic [CNT_W-1:0] EX_LAST = CNT_W'(ALU_LAT - 1);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] FN_SHL   = 6'h01;
    localparam logic [5:0] FN_SHR   = 6'h02;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2,
        S_WB   = 2'd3
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;

    logic [5:0]            opcode_reg;
    logic [5:0]            funct_reg;
    logic [4:0]            shamt_reg;
    logic [15:0]           imm_reg;

    logic                  read_reg, write_reg, busy_reg, done_reg, err_reg, err_next;
    logic [DATA_WIDTH-1:0] op1_reg, op1_next;
    logic [DATA_WIDTH-1:0] op2_reg, op2_next;
    logic [5:0]            code_reg, code_next;

    logic                  opcode_legal;
    logic                  can_take;
    logic                  accept;
    logic                  alu_load;

    always_comb begin
        opcode_legal = 1'b0;
        case (bus.OpCode)
            OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: opcode_legal = 1'b1;
            default:                                    opcode_legal = 1'b0;
        endcase
    end

    // A NOP is silently dropped; anything else unknown is rejected with ERR.
    assign can_take = ((state_reg == S_IDLE) || (state_reg == S_WB)) &&
                      bus.START && (bus.OpCode != NOP_OPCODE);
    assign accept   = can_take && opcode_legal;
    assign alu_load = (state_reg == S_EX) && (cnt_reg == '0);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        err_next   = can_take && !opcode_legal;
        case (state_reg)
            S_IDLE: begin
                if (accept) begin
                    state_next = S_RD;
                    cnt_next   = '0;
                end
            end
            S_RD: begin
                if (cnt_reg == RD_LAST) begin
                    state_next = S_EX;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_EX: begin
                if (cnt_reg == EX_LAST) begin
                    state_next = S_WB;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            S_WB: begin
                state_next = accept ? S_RD : S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Operands are formed from the latched instruction and the register-file data of this cycle.
    always_comb begin
        code_next = code_reg;
        op1_next  = op1_reg;
        op2_next  = op2_reg;
        case (opcode_reg)
            OP_RTYPE: begin
                code_next = funct_reg;
                op1_next  = bus.DATA_R1;
                if ((funct_reg == FN_SHL) || (funct_reg == FN_SHR)) begin
                    op2_next = {{(DATA_WIDTH-5){1'b0}}, shamt_reg};
                end else begin
                    op2_next = bus.DATA_R2;
                end
            end
            OP_ADDI: begin
                code_next = 6'h20;
                op1_next  = bus.DATA_R1;
                op2_next  = {{(DATA_WIDTH-16){imm_reg[15]}}, imm_reg};
            end
            OP_ANDI: begin
                code_next = 6'h24;
                op1_next  = bus.DATA_R1;
                op2_next  = {{(DATA_WIDTH-16){1'b0}}, imm_reg};
            end
            OP_ORI: begin
                code_next = 6'h25;
                op1_next  = bus.DATA_R1;
                op2_next  = {{(DATA_WIDTH-16){1'b0}}, imm_reg};
            end
            OP_LUI: begin
                code_next = 6'h01;
                op1_next  = {{(DATA_WIDTH-16){1'b0}}, imm_reg};
                op2_next  = DATA_WIDTH'(16);
            end
            default: begin
                code_next = code_reg;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= S_IDLE;
            cnt_reg    <= '0;
            opcode_reg <= '0;
            funct_reg  <= '0;
            shamt_reg  <= '0;
            imm_reg    <= '0;
            read_reg   <= 1'b0;
            write_reg  <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
            op1_reg    <= '0;
            op2_reg    <= '0;
            code_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (accept) begin
                opcode_reg <= bus.OpCode;
                funct_reg  <= bus.Funct;
                shamt_reg  <= bus.Shamt;
                imm_reg    <= bus.Imm16;
            end
            if (alu_load) begin
                op1_reg  <= op1_next;
                op2_reg  <= op2_next;
                code_reg <= code_next;
            end
            read_reg  <= (state_reg == S_RD);
            write_reg <= (state_reg == S_WB);
            busy_reg  <= (state_reg == S_RD) || (state_reg == S_EX);
            done_reg  <= (state_reg == S_WB);
            err_reg   <= err_next;
        end
    end

    assign bus.READ     = read_reg;
    assign bus.WRITE    = write_reg;
    assign bus.BUSY     = busy_reg;
    assign bus.DONE     = done_reg;
    assign bus.ERR      = err_reg;
    assign bus.ALU_OP1  = op1_reg;
    assign bus.ALU_OP2  = op2_reg;
    assign bus.ALU_Code = code_reg;

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Bench for mips_ctrl_fsm: two instances (R=1/A=1 and R=3/A=2) share one stimulus stream;
// a per-instance scoreboard checks operands and write-back cycle of every instruction.
module tb_mips_ctrl_fsm;

    localparam int DW = 32;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  funct;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [5:0]  code;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        legal;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic [5:0]  code;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] wcyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] data_r1;
    logic [31:0] data_r2;

    logic [1:0]  rd_o, wr_o, busy_o, done_o, err_o;
    logic [5:0]  code_o [2];
    logic [31:0] op1_o  [2];
    logic [31:0] op2_o  [2];

    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          rlen [2];
    logic [5:0]  last_code;
    exp_t        sbq [2][$];
    vec_t        tbl [12];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dut
            mips_ctrl_fsm_if #(.DATA_WIDTH(DW)) bus ();
            assign bus.START   = start;
            assign bus.OpCode  = opcode;
            assign bus.Funct   = funct;
            assign bus.Shamt   = shamt;
            assign bus.Imm16   = imm;
            assign bus.DATA_R1 = data_r1;
            assign bus.DATA_R2 = data_r2;
            assign rd_o[gi]    = bus.READ;
            assign wr_o[gi]    = bus.WRITE;
            assign busy_o[gi]  = bus.BUSY;
            assign done_o[gi]  = bus.DONE;
            assign err_o[gi]   = bus.ERR;
            assign code_o[gi]  = bus.ALU_Code;
            assign op1_o[gi]   = bus.ALU_OP1;
            assign op2_o[gi]   = bus.ALU_OP2;

            mips_ctrl_fsm #(
                .DATA_WIDTH (DW),
                .RF_READ_LAT((gi == 0) ? 1 : 3),
                .ALU_LAT    ((gi == 0) ? 1 : 2),
                .NOP_OPCODE (6'd63)
            ) u_dut (
                .CLK(clk),
                .RST(rst),
                .bus(bus.slave)
            );
        end
    endgenerate

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int rlat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int alat(input int d);
        return (d == 0) ? 1 : 2;
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                input logic [15:0] im, input logic [31:0] a, input logic [31:0] b,
                                input logic [5:0] code, input logic [31:0] o1, input logic [31:0] o2,
                                input logic legal, input logic err);
        vec_t v;
        v.op = op; v.funct = fn; v.sh = sh; v.imm = im; v.d1 = a; v.d2 = b;
        v.code = code; v.op1 = o1; v.op2 = o2; v.legal = legal; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @cyc %0d: got 0x%0h, expected 0x%0h", name, d, cyc, act, exp);
        end
    endtask

    // Advance to the next falling edge and run the per-cycle monitor for both instances.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            if (rd_o[d] === 1'b1 || wr_o[d] === 1'b1)
                chk("read_write_exclusive", d, 64'(rd_o[d] & wr_o[d]), 64'd0);
            if (rd_o[d] === 1'b1) begin
                rlen[d]++;
            end else if (rlen[d] != 0) begin
                chk("read_length", d, 64'(rlen[d]), 64'(rlat(d)));
                rlen[d] = 0;
            end
            if (wr_o[d] === 1'b1 || done_o[d] === 1'b1) begin
                if (sbq[d].size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write dut%0d @cyc %0d: got write=%b done=%b, expected none",
                             d, cyc, wr_o[d], done_o[d]);
                end else begin
                    e = sbq[d].pop_front();
                    chk("write_done_pair", d, 64'({wr_o[d], done_o[d]}), 64'b11);
                    chk("write_cycle", d, 64'(cyc), 64'(e.wcyc));
                    chk("alu_code", d, 64'(code_o[d]), 64'(e.code));
                    chk("alu_op1", d, 64'(op1_o[d]), 64'(e.op1));
                    chk("alu_op2", d, 64'(op2_o[d]), 64'(e.op2));
                end
            end
        end
    endtask

    task automatic push_exp(input int d, input vec_t v, input int k);
        exp_t e;
        e.code = v.code;
        e.op1  = v.op1;
        e.op2  = v.op2;
        e.wcyc = 32'(k + rlat(d) + alat(d) + 1);
        sbq[d].push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sbq[0].size() != 0 || sbq[1].size() != 0) && n < 40) begin
            tick();
            n++;
        end
        if (sbq[0].size() != 0 || sbq[1].size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d/%0d pending writes, expected 0/0",
                     sbq[0].size(), sbq[1].size());
            sbq[0].delete();
            sbq[1].delete();
        end
    endtask

    task automatic drive(input vec_t v);
        opcode = v.op; funct = v.funct; shamt = v.sh; imm = v.imm;
        data_r1 = v.d1; data_r2 = v.d2;
    endtask

    task automatic run_entry(input vec_t v);
        int k;
        drive(v);
        start = 1'b1;
        tick();
        k = cyc;
        start  = 1'b0;
        opcode = 6'h2B; funct = 6'h3F; shamt = 5'h1F; imm = 16'hA5A5;
        if (v.legal) begin
            for (int d = 0; d < 2; d++) begin
                push_exp(d, v, k);
                chk("no_err_on_accept", d, 64'(err_o[d]), 64'd0);
                chk("busy_low_accept_cycle", d, 64'(busy_o[d]), 64'd0);
            end
            tick();
            for (int d = 0; d < 2; d++)
                chk("read_busy_start", d, 64'({busy_o[d], rd_o[d]}), 64'b11);
            wait_drain();
            tick();
            for (int d = 0; d < 2; d++)
                chk("alu_code_retained", d, 64'(code_o[d]), 64'(v.code));
            last_code = v.code;
        end else begin
            for (int d = 0; d < 2; d++) begin
                chk("err_pulse", d, 64'(err_o[d]), 64'(v.err));
                chk("busy_after_reject", d, 64'(busy_o[d]), 64'd0);
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                chk("err_clear", d, 64'(err_o[d]), 64'd0);
                chk("no_read_write", d, 64'({rd_o[d], wr_o[d]}), 64'd0);
                chk("alu_code_unchanged", d, 64'(code_o[d]), 64'(last_code));
            end
        end
    endtask

    initial begin
        int k;
        vec_t v;
        rlen[0] = 0; rlen[1] = 0;
        last_code = 6'h00;

        tbl[0]  = mk(6'h00, 6'h20, 5'd7,  16'h0000, 32'd5,        32'd7,      6'h20, 32'd5,        32'd7,        1, 0);
        tbl[1]  = mk(6'h00, 6'h01, 5'd3,  16'h0000, 32'h80,       32'hFFFF,   6'h01, 32'h80,       32'd3,        1, 0);
        tbl[2]  = mk(6'h00, 6'h02, 5'd31, 16'h0000, 32'hF0000000, 32'h1234,   6'h02, 32'hF0000000, 32'd31,       1, 0);
        tbl[3]  = mk(6'h00, 6'h22, 5'd9,  16'h0000, 32'd9,        32'd4,      6'h22, 32'd9,        32'd4,        1, 0);
        tbl[4]  = mk(6'h08, 6'h00, 5'd0,  16'hFFFE, 32'd10,       32'd99,     6'h20, 32'd10,       32'hFFFFFFFE, 1, 0);
        tbl[5]  = mk(6'h08, 6'h00, 5'd0,  16'h7FFF, 32'd1,        32'd99,     6'h20, 32'd1,        32'h00007FFF, 1, 0);
        tbl[6]  = mk(6'h0C, 6'h00, 5'd0,  16'h8000, 32'hFFFFFFFF, 32'd0,      6'h24, 32'hFFFFFFFF, 32'h00008000, 1, 0);
        tbl[7]  = mk(6'h0D, 6'h00, 5'd0,  16'hFFFE, 32'h100,      32'd0,      6'h25, 32'h100,      32'h0000FFFE, 1, 0);
        tbl[8]  = mk(6'h0F, 6'h00, 5'd0,  16'h1234, 32'hDEAD,     32'hBEEF,   6'h01, 32'h1234,     32'd16,       1, 0);
        tbl[9]  = mk(6'h23, 6'h00, 5'd0,  16'h0000, 32'd1,        32'd2,      6'h00, 32'd0,        32'd0,        0, 1);
        tbl[10] = mk(6'h3F, 6'h20, 5'd0,  16'h0000, 32'd1,        32'd2,      6'h00, 32'd0,        32'd0,        0, 0);
        tbl[11] = mk(6'h04, 6'h00, 5'd0,  16'h0001, 32'd1,        32'd2,      6'h00, 32'd0,        32'd0,        0, 1);

        // Reset held for two edges with a legal START pending.
        rst = 1'b1;
        drive(tbl[0]);
        start = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("reset_ctrl_outputs", d, 64'({rd_o[d], wr_o[d], busy_o[d], done_o[d], err_o[d]}), 64'd0);
            chk("reset_alu_code", d, 64'(code_o[d]), 64'd0);
            chk("reset_alu_ops", d, {op1_o[d], op2_o[d]}, 64'd0);
        end
        rst = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++)
            chk("idle_after_reset", d, 64'({busy_o[d], rd_o[d], wr_o[d]}), 64'd0);

        for (int i = 0; i < 12; i++)
            run_entry(tbl[i]);

        // START held high: each instance re-accepts once per R+A+1 cycles.
        v = mk(6'h08, 6'h00, 5'd0, 16'hFFF0, 32'd100, 32'd0, 6'h20, 32'd100, 32'hFFFFFFF0, 1, 0);
        drive(v);
        start = 1'b1;
        tick();
        k = cyc;
        for (int d = 0; d < 2; d++) begin
            for (int j = 0; j * (rlat(d) + alat(d) + 1) <= 12; j++)
                push_exp(d, v, k + j * (rlat(d) + alat(d) + 1));
        end
        repeat (12) tick();
        start = 1'b0;
        wait_drain();
        repeat (2) tick();

        // START pulsed again while both instances are busy: must be ignored.
        drive(v);
        start = 1'b1;
        tick();
        k = cyc;
        for (int d = 0; d < 2; d++) push_exp(d, v, k);
        start = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_drain();
        repeat (4) tick();

        // Reset while the slow instance is executing aborts the instruction.
        v = mk(6'h00, 6'h20, 5'd0, 16'h0000, 32'd3, 32'd4, 6'h20, 32'd3, 32'd4, 1, 0);
        drive(v);
        start = 1'b1;
        tick();
        k = cyc;
        start = 1'b0;
        for (int d = 0; d < 2; d++) push_exp(d, v, k);
        repeat (4) tick();
        chk("ex_busy", 1, 64'(busy_o[1]), 64'd1);
        chk("ex_alu_code", 1, 64'(code_o[1]), 64'h20);
        chk("ex_alu_op1", 1, 64'(op1_o[1]), 64'd3);
        rst = 1'b1;
        sbq[1].delete();
        tick();
        for (int d = 0; d < 2; d++) begin
            chk("abort_ctrl_outputs", d, 64'({rd_o[d], wr_o[d], busy_o[d], done_o[d], err_o[d]}), 64'd0);
            chk("abort_alu", d, {op1_o[d], op2_o[d]}, 64'd0);
        end
        rst = 1'b0;
        repeat (6) tick();
        last_code = 6'h00;
        run_entry(tbl[4]);
        run_entry(tbl[8]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
